// File: rtl/enc_pipe_param.sv
// ARX block-encryption pipeline, one round per stage; ENC_CTRL_BYPASS_EN passes ctrl!=0 beats through unmodified.
// Latency NUM_ROUNDS cycles plus one per stall cycle; a stalled output freezes every stage and drops in_rdy.
module enc_pipe_param #(
    parameter int WORD_W     = 16,
    parameter int NUM_ROUNDS = 8,
    parameter int CTRL_W     = 8,
    localparam int DATA_W    = 4 * WORD_W,
    localparam int KEY_W     = 5 * WORD_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_wr,
    output logic              in_rdy,
    input  logic [KEY_W-1:0]  key,
    input  logic              key_wr,
    output logic              key_rej,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_wr,
    input  logic              out_rdy,
    output logic              busy
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] dat;
    } beat_t;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input int n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    function automatic logic [DATA_W-1:0] enc_round(input logic [DATA_W-1:0] d,
                                                    input logic [WORD_W-1:0] rk);
        logic [WORD_W-1:0] a, b, c, e;
        a = d[4*WORD_W-1 -: WORD_W] + rk;
        b = d[3*WORD_W-1 -: WORD_W] ^ rotl(a, 3);
        c = d[2*WORD_W-1 -: WORD_W] + b;
        e = d[WORD_W-1:0] ^ rotl(c, 5);
        return {b, c, e, a};
    endfunction

    logic [NUM_ROUNDS-1:0] vld_q;
    logic [NUM_ROUNDS-1:0] vld_d;
    beat_t                 stg_q   [NUM_ROUNDS];
    beat_t                 stg_d   [NUM_ROUNDS];
    beat_t                 stg_src [NUM_ROUNDS];
    logic [WORD_W-1:0]     rk      [NUM_ROUNDS];
    logic [KEY_W-1:0]      key_q;
    logic                  key_rej_q;
    logic                  advance;
    logic                  accept;

    assign advance = !vld_q[NUM_ROUNDS-1] || out_rdy;
    assign accept  = in_wr && advance;

    // Stage r consumes the input port (r==0) or the register of stage r-1.
    always_comb begin
        stg_src[0].ctrl = in_ctrl;
        stg_src[0].dat  = in_data;
        vld_d[0]        = in_wr;
        for (int r = 1; r < NUM_ROUNDS; r++) begin
            stg_src[r] = stg_q[r-1];
            vld_d[r]   = vld_q[r-1];
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_ROUNDS; r++) begin
            rk[r]         = key_q[(r % 5) * WORD_W +: WORD_W] ^ WORD_W'(r);
            stg_d[r].ctrl = stg_src[r].ctrl;
            stg_d[r].dat  = enc_round(stg_src[r].dat, rk[r]);
`ifdef ENC_CTRL_BYPASS_EN
            if (stg_src[r].ctrl != '0) begin
                stg_d[r].dat = stg_src[r].dat;
            end
`endif
        end
    end

    // Key may only change with the pipe empty and no beat entering, so every beat sees one key.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q     <= '0;
            key_q     <= '0;
            key_rej_q <= 1'b0;
            for (int r = 0; r < NUM_ROUNDS; r++) begin
                stg_q[r] <= '0;
            end
        end else begin
            key_rej_q <= key_wr && (busy || accept);
            if (key_wr && !busy && !accept) begin
                key_q <= key;
            end
            if (advance) begin
                vld_q <= vld_d;
                for (int r = 0; r < NUM_ROUNDS; r++) begin
                    stg_q[r] <= stg_d[r];
                end
            end
        end
    end

    assign in_rdy   = advance;
    assign out_wr   = vld_q[NUM_ROUNDS-1];
    assign out_data = stg_q[NUM_ROUNDS-1].dat;
    assign out_ctrl = stg_q[NUM_ROUNDS-1].ctrl;
    assign busy     = |vld_q;
    assign key_rej  = key_rej_q;

endmodule
